// File: rtl/sign_ext.sv
// LEGv8 immediate generator: decodes the opcode and extends the immediate field to OUT_W bits, registered.
// Define SIGN_EXT_FULL_ISA_EN to add the B/BL, B.cond and ADDI/SUBI decodes.
module sign_ext #(
    parameter int unsigned OUT_W = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [31:0]      a,
    output logic             out_valid,
    output logic [OUT_W-1:0] y,
    output logic [2:0]       fmt,
    output logic             illegal
);

    localparam int unsigned FMT_W   = 3;
    localparam int unsigned D_W     = 9;
    localparam int unsigned CB_W    = 19;
    localparam int unsigned B_W     = 26;
    localparam int unsigned I_W     = 12;

    typedef enum logic [FMT_W-1:0] {
        FMT_NONE  = 3'd0,
        FMT_D     = 3'd1,
        FMT_CB    = 3'd2,
        FMT_B     = 3'd3,
        FMT_BCOND = 3'd4,
        FMT_I     = 3'd5
    } fmt_e;

    localparam logic [10:0] OP_LDUR  = 11'b11111000010;
    localparam logic [10:0] OP_STUR  = 11'b11111000000;
    localparam logic [7:0]  OP_CBZ   = 8'b10110100;
    localparam logic [7:0]  OP_CBNZ  = 8'b10110101;
`ifdef SIGN_EXT_FULL_ISA_EN
    localparam logic [5:0]  OP_B     = 6'b000101;
    localparam logic [5:0]  OP_BL    = 6'b100101;
    localparam logic [7:0]  OP_BCOND = 8'b01010100;
    localparam logic [9:0]  OP_ADDI  = 10'b1001000100;
    localparam logic [9:0]  OP_SUBI  = 10'b1101000100;
`endif

    if (OUT_W < 32 || OUT_W > 64) begin : g_bad_out_w
        $error("sign_ext: OUT_W must be in 32..64");
    end

    logic             out_valid_q;
    logic [OUT_W-1:0] y_q,       y_d;
    fmt_e             fmt_q,     fmt_d;
    logic             illegal_q, illegal_d;

    // Low bits only matter to B/BL in the full decode; fold them so they never appear dangling.
    logic unused_low_bits_c;
    assign unused_low_bits_c = ^a[4:0];

    // Opcode decode and immediate extension; opcode patterns are mutually exclusive.
    always_comb begin
        y_d       = '0;
        fmt_d     = FMT_NONE;
        illegal_d = 1'b1;
        if (a[31:21] == OP_LDUR || a[31:21] == OP_STUR) begin
            y_d       = {{(OUT_W-D_W){a[20]}}, a[20:12]};
            fmt_d     = FMT_D;
            illegal_d = 1'b0;
        end else if (a[31:24] == OP_CBZ || a[31:24] == OP_CBNZ) begin
            y_d       = {{(OUT_W-CB_W){a[23]}}, a[23:5]};
            fmt_d     = FMT_CB;
            illegal_d = 1'b0;
        end
`ifdef SIGN_EXT_FULL_ISA_EN
        else if (a[31:26] == OP_B || a[31:26] == OP_BL) begin
            y_d       = {{(OUT_W-B_W){a[25]}}, a[25:0]};
            fmt_d     = FMT_B;
            illegal_d = 1'b0;
        end else if (a[31:24] == OP_BCOND) begin
            y_d       = {{(OUT_W-CB_W){a[23]}}, a[23:5]};
            fmt_d     = FMT_BCOND;
            illegal_d = 1'b0;
        end else if (a[31:22] == OP_ADDI || a[31:22] == OP_SUBI) begin
            y_d       = {{(OUT_W-I_W){1'b0}}, a[21:10]};
            fmt_d     = FMT_I;
            illegal_d = 1'b0;
        end
`endif
    end

    // Result register: loads on every accepted instruction, holds otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            y_q         <= '0;
            fmt_q       <= FMT_NONE;
            illegal_q   <= 1'b0;
        end else begin
            out_valid_q <= in_valid;
            if (in_valid) begin
                y_q       <= y_d;
                fmt_q     <= fmt_d;
                illegal_q <= illegal_d;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign y         = y_q;
    assign fmt       = fmt_q;
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_sign_ext.sv
// Directed self-checking bench for sign_ext; covers both builds via SIGN_EXT_FULL_ISA_EN.
module tb_sign_ext;

    localparam int unsigned OUT_W = 64;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic [31:0]      a;
    logic             out_valid;
    logic [OUT_W-1:0] y;
    logic [2:0]       fmt;
    logic             illegal;

    int tests_run = 0;
    int tests_failed = 0;

    sign_ext #(.OUT_W(OUT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .out_valid (out_valid),
        .y         (y),
        .fmt       (fmt),
        .illegal   (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one instruction, step one edge, leave outputs ready to sample 1 time unit later.
    task automatic issue(input logic [31:0] instr);
        in_valid = 1'b1;
        a        = instr;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        a        = 32'hDEADBEEF;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        a        = '0;
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if ({out_valid, y, fmt, illegal} !== {1'b0, 64'h0, 3'd0, 1'b0}) begin
            tests_failed++;
            $display("FAIL reset_por: got v=%b y=%h fmt=%0d ill=%b want v=0 y=0 fmt=0 ill=0",
                     out_valid, y, fmt, illegal);
        end
        rst_n = 1'b1;
        #2;
        // Mid-stream asynchronous reset with a nonzero result in flight.
        issue(32'hF8500041);
        in_valid = 1'b1;
        a        = 32'hB4FFFEC1;
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({out_valid, y, fmt, illegal} !== {1'b0, 64'h0, 3'd0, 1'b0}) begin
            tests_failed++;
            $display("FAIL reset_async: got v=%b y=%h fmt=%0d ill=%b want v=0 y=0 fmt=0 ill=0",
                     out_valid, y, fmt, illegal);
        end
        @(posedge clk);
        #1;
        tests_run++;
        if ({out_valid, y, fmt, illegal} !== {1'b0, 64'h0, 3'd0, 1'b0}) begin
            tests_failed++;
            $display("FAIL reset_held: got v=%b y=%h fmt=%0d ill=%b want all zero",
                     out_valid, y, fmt, illegal);
        end
        in_valid = 1'b0;
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_d_format();
        logic [31:0]      vec_a [3]   = '{32'hF8500041, 32'hF842C083, 32'hF80FF000};
        logic [OUT_W-1:0] vec_y [3]   = '{64'hFFFFFFFFFFFFFF00, 64'h000000000000002C, 64'h00000000000000FF};
        for (int i = 0; i < 3; i++) begin
            issue(vec_a[i]);
            tests_run++;
            if ({out_valid, y, fmt, illegal} !== {1'b1, vec_y[i], 3'd1, 1'b0}) begin
                tests_failed++;
                $display("FAIL d_fmt[%0d] a=%h: got v=%b y=%h fmt=%0d ill=%b want v=1 y=%h fmt=1 ill=0",
                         i, vec_a[i], out_valid, y, fmt, illegal, vec_y[i]);
            end
        end
    endtask

    task automatic test_cb_format();
        logic [31:0]      vec_a [3] = '{32'hB4FFFEC1, 32'hB57FFFE0, 32'hB4800000};
        logic [OUT_W-1:0] vec_y [3] = '{64'hFFFFFFFFFFFFFFF6, 64'h000000000003FFFF, 64'hFFFFFFFFFFFC0000};
        for (int i = 0; i < 3; i++) begin
            issue(vec_a[i]);
            tests_run++;
            if ({out_valid, y, fmt, illegal} !== {1'b1, vec_y[i], 3'd2, 1'b0}) begin
                tests_failed++;
                $display("FAIL cb_fmt[%0d] a=%h: got v=%b y=%h fmt=%0d ill=%b want v=1 y=%h fmt=2 ill=0",
                         i, vec_a[i], out_valid, y, fmt, illegal, vec_y[i]);
            end
        end
    endtask

    task automatic test_illegal();
        logic [31:0] vec_a [3] = '{32'h00000000, 32'hE2000000, 32'hF8600000};
        for (int i = 0; i < 3; i++) begin
            issue(vec_a[i]);
            tests_run++;
            if ({out_valid, y, fmt, illegal} !== {1'b1, 64'h0, 3'd0, 1'b1}) begin
                tests_failed++;
                $display("FAIL illegal[%0d] a=%h: got v=%b y=%h fmt=%0d ill=%b want v=1 y=0 fmt=0 ill=1",
                         i, vec_a[i], out_valid, y, fmt, illegal);
            end
        end
        idle();
        tests_run++;
        if ({out_valid, y, fmt, illegal} !== {1'b0, 64'h0, 3'd0, 1'b1}) begin
            tests_failed++;
            $display("FAIL illegal_hold: got v=%b y=%h fmt=%0d ill=%b want v=0 y=0 fmt=0 ill=1",
                     out_valid, y, fmt, illegal);
        end
    endtask

    task automatic test_hold();
        issue(32'hF8500041);
        idle();
        idle();
        tests_run++;
        if ({out_valid, y, fmt, illegal} !== {1'b0, 64'hFFFFFFFFFFFFFF00, 3'd1, 1'b0}) begin
            tests_failed++;
            $display("FAIL hold: got v=%b y=%h fmt=%0d ill=%b want v=0 y=ffffffffffffff00 fmt=1 ill=0",
                     out_valid, y, fmt, illegal);
        end
    endtask

    task automatic test_full_isa();
        logic [31:0]      vec_a   [5] = '{32'h17FFFFFF, 32'h96000000, 32'h54FFFEC1, 32'h913FFC00, 32'hD1200000};
`ifdef SIGN_EXT_FULL_ISA_EN
        logic [OUT_W-1:0] vec_y   [5] = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFE000000, 64'hFFFFFFFFFFFFFFF6,
                                          64'h0000000000000FFF, 64'h0000000000000800};
        logic [2:0]       vec_fmt [5] = '{3'd3, 3'd3, 3'd4, 3'd5, 3'd5};
        logic             vec_ill [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`else
        logic [OUT_W-1:0] vec_y   [5] = '{64'h0, 64'h0, 64'h0, 64'h0, 64'h0};
        logic [2:0]       vec_fmt [5] = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
        logic             vec_ill [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
`endif
        for (int i = 0; i < 5; i++) begin
            issue(vec_a[i]);
            tests_run++;
            if ({out_valid, y, fmt, illegal} !== {1'b1, vec_y[i], vec_fmt[i], vec_ill[i]}) begin
                tests_failed++;
                $display("FAIL full_isa[%0d] a=%h: got v=%b y=%h fmt=%0d ill=%b want v=1 y=%h fmt=%0d ill=%b",
                         i, vec_a[i], out_valid, y, fmt, illegal, vec_y[i], vec_fmt[i], vec_ill[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0]      vec_a   [4] = '{32'hB4FFFEC1, 32'hE2000000, 32'hF842C083, 32'hB57FFFE0};
        logic [OUT_W-1:0] vec_y   [4] = '{64'hFFFFFFFFFFFFFFF6, 64'h0, 64'h000000000000002C, 64'h000000000003FFFF};
        logic [2:0]       vec_fmt [4] = '{3'd2, 3'd0, 3'd1, 3'd2};
        logic             vec_ill [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 4; i++) begin
            issue(vec_a[i]);
            tests_run++;
            if ({out_valid, y, fmt, illegal} !== {1'b1, vec_y[i], vec_fmt[i], vec_ill[i]}) begin
                tests_failed++;
                $display("FAIL b2b[%0d] a=%h: got v=%b y=%h fmt=%0d ill=%b want v=1 y=%h fmt=%0d ill=%b",
                         i, vec_a[i], out_valid, y, fmt, illegal, vec_y[i], vec_fmt[i], vec_ill[i]);
            end
        end
        idle();
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_idle: got out_valid=%b want 0", out_valid);
        end
    endtask

    initial begin
        in_valid = 1'b0;
        a        = '0;
        rst_n    = 1'b1;
        #1;
        test_reset();
        test_d_format();
        test_cb_format();
        test_illegal();
        test_hold();
        test_full_isa();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
